frame_payload_extractor: RTL
============================

// Module: frame_payload_extractor
// PURPOSE
// - Hunts the incoming sample stream for a header of HDR_LEN consecutive HDR_WORD samples.
// - Forwards the next payload_len valid samples to the FFT input stage as a framed packet.
// - Drives out_sop on the first payload sample and out_eop on the last.
// - Successor to the fixed 3-word / 10-sample / 16-bit header detector. Adds:
//   - parametrised width and header length;
//   - run-time payload length;
//   - input valid qualification and a registered framed output;
//   - frame and error counters.
// PARAMETERS
// - DATA_W    16       sample width in bits
// - HDR_WORD  16'hFFFF header sample value, width DATA_W
// - HDR_LEN   3        consecutive header samples required, 1..15
// - LEN_W     10       width of payload_len and of the payload counter
// PORTS
// - clk          in   1      single clock, all logic on rising edge
// - rst_n        in   1      synchronous reset, active low
// - in_data      in   DATA_W input sample
// - in_valid     in   1      in_data qualifier; cycles with in_valid=0 are ignored
// - payload_len  in   LEN_W  payload samples per frame, sampled at header lock
// - out_data     out  DATA_W payload sample; forced to 0 whenever out_valid=0
// - out_valid    out  1      out_data carries a payload sample
// - out_sop      out  1      first payload sample of a frame
// - out_eop      out  1      last payload sample of a frame
// - frame_cnt    out  16     completed frames, wraps at 16'hFFFF->0
// - hdr_err_cnt  out  16     partial headers aborted, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - state=HUNT, match count=0, payload count=0.
//   - All outputs are 0 from the next cycle.
// - Only words with in_valid=1 advance the FSM or the counters. A valid=0 cycle stalls everything:
//   - it does not break a header run;
//   - it does not end a payload;
//   - out_valid=0 for that cycle.
// - HUNT, on valid HDR_WORD:
//   - match=1;
//   - goes to HDR if HDR_LEN>1, else goes to LOCK.
// - HDR, on valid HDR_WORD:
//   - match++;
//   - when match reaches HDR_LEN, goes to LOCK and latches payload_len into len_q.
// - HDR, on a valid non-header word:
//   - returns to HUNT, match=0, hdr_err_cnt++ (saturating).
//   - The breaking word is not re-examined as a new header start.
// - LOCK is entered on the edge that accepts the last header word:
//   - len_q=0: the frame is dropped. Next state is HUNT, no output, frame_cnt unchanged.
//   - otherwise: next state is PAYLOAD, payload count=0.
// - PAYLOAD, on each valid word:
//   - the word is forwarded, even if it equals HDR_WORD; header runs inside the payload are ignored.
//   - Registered outputs on the next cycle:
//     - out_valid=1, out_data=word;
//     - out_sop=(count==0), out_eop=(count==len_q-1).
//   - On the last word: next state is HUNT and frame_cnt++.
//   - len_q=1 gives sop and eop in the same cycle.
// - Latency: exactly 1 clk from the accepting edge of a payload word to its output cycle.
// - Header words beyond HDR_LEN: the first valid word after lock is payload, even if it equals HDR_WORD.
// - A payload_len change during PAYLOAD has no effect until the next lock.
// - Reset in the middle of a frame:
//   - aborts the frame; no eop is emitted;
//   - both counters clear to 0.
// - Widths:
//   - the payload counter is LEN_W bits and compares against len_q-1 computed in LEN_W bits;
//   - len_q=0 never reaches PAYLOAD.
// STRUCTURE
// - Shared package frame_pkg:
//   - FSM state encoding (HUNT, HDR, PAYLOAD; LOCK is the transition edge, not a held state);
//   - defaults DATA_W=16, HDR_WORD=16'hFFFF, LEN_W=10.
// - One sub-module, hdr_run_matcher:
//   - counts consecutive valid HDR_WORD samples;
//   - outputs lock (the HDR_LEN-th match) and abort (a run broken after >=1 match).
// - The top level holds the payload counter, len_q, the output register and the two statistics counters.
// TESTING
// - Defaults with payload_len=10. Feed FFFF,FFFF,FFFF,1..10, all valid.
//   -> out_valid high for 10 cycles, out_data 1..10, sop on 1, eop on 10, frame_cnt=1.
// - Feed FFFF,FFFF,0005,FFFF,FFFF,FFFF,A..
//   -> hdr_err_cnt=1, then a normal frame starting at A.
// - in_valid=0 inserted between header words and mid-payload (2 idle cycles each).
//   -> same output samples as the gapless case; out_valid=0 on the gaps; one frame.
// - 4 x FFFF then 0x0001. -> the payload's first word is FFFF with sop, followed by 0001.
// - payload_len=0 after 3 x FFFF. -> no out_valid; frame_cnt unchanged; the next header is detected normally.
// - payload_len=1. -> single cycle with sop=eop=1.
// - rst_n=0 during payload sample 5. -> outputs 0 next cycle; counters 0; state HUNT.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame payload extractor and its header matcher.
package frame_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   localparam int          DEF_DATA_W   = 16;
   localparam logic [15:0] DEF_HDR_WORD = 16'hFFFF;
   localparam int          DEF_LEN_W    = 10;
   localparam int          MATCH_W      = 4;   // holds a header run of up to 15

endpackage

// File: rtl/frame_payload_extractor_hdr_run_matcher.sv
// Counts consecutive qualified header samples; flags the locking match and a broken partial run.
module hdr_run_matcher
   import frame_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [DATA_W-1:0] HDR_WORD = DATA_W'(DEF_HDR_WORD),
   parameter int                HDR_LEN  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   output logic              hit,
   output logic              lock,
   output logic              abort
);

   logic [MATCH_W-1:0] match_q;
   logic               is_hdr;

   // NOTE: combinational outputs get a value on every path so no latch is inferred.
   always_comb begin
      is_hdr = (data == HDR_WORD);
      hit    = en && is_hdr;
      lock   = hit && (match_q == MATCH_W'(HDR_LEN - 1));
      abort  = en && !is_hdr && (match_q != '0);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         match_q <= '0;
      end else if (lock || (en && !is_hdr)) begin
         match_q <= '0;
      end else if (hit) begin
         match_q <= match_q + 1'b1;
      end
   end

endmodule

// File: rtl/frame_payload_extractor.sv
// Locks onto an HDR_LEN-long header run and forwards the following payload_len valid samples as a framed packet.
module frame_payload_extractor
   import frame_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [DATA_W-1:0] HDR_WORD = DATA_W'(DEF_HDR_WORD),
   parameter int                HDR_LEN  = 3,
   parameter int                LEN_W    = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic [LEN_W-1:0]  payload_len,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_sop,
   output logic              out_eop,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       hdr_err_cnt
);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt_q;
   logic               hit, lock, abort;
   logic               fwd, last;

   // The matcher is frozen during payload so header-like samples there are just data.
   hdr_run_matcher #(
      .DATA_W   (DATA_W),
      .HDR_WORD (HDR_WORD),
      .HDR_LEN  (HDR_LEN)
   ) u_matcher (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_valid && (state_q != PAYLOAD)),
      .data  (in_data),
      .hit   (hit),
      .lock  (lock),
      .abort (abort)
   );

   always_comb begin
      state_d = state_q;
      fwd     = in_valid && (state_q == PAYLOAD);
      last    = (cnt_q == len_q - LEN_W'(1));
      case (state_q)
         HUNT, HDR: begin
            if (lock)       state_d = (payload_len != '0) ? PAYLOAD : HUNT;
            else if (abort) state_d = HUNT;
            else if (hit)   state_d = HDR;
         end
         PAYLOAD: begin
            if (fwd && last) state_d = HUNT;
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         len_q       <= '0;
         cnt_q       <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         frame_cnt   <= '0;
         hdr_err_cnt <= '0;
      end else begin
         state_q   <= state_d;
         out_valid <= fwd;
         out_data  <= fwd ? in_data : '0;
         out_sop   <= fwd && (cnt_q == '0);
         out_eop   <= fwd && last;
         if (lock) begin
            len_q <= payload_len;
            cnt_q <= '0;
         end else if (fwd) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (fwd && last)
            frame_cnt <= frame_cnt + 16'd1;
         if (abort && (hdr_err_cnt != 16'hFFFF))
            hdr_err_cnt <= hdr_err_cnt + 16'd1;
      end
   end

endmodule
